// File: rtl/io_periph_regs.sv
// IO register block on the VexRiscv dBus: LEDs, RGB PWM settings, buttons, switches, UART RX FIFO and TX byte port.
// Commands accepted every cycle, read data one cycle later; TX is valid/ready; `define IO_IRQ_EN adds IRQ_MASK and irq.
module io_periph_regs #(
  parameter int NUM_LEDS      = 4,
  parameter int NUM_RGB       = 2,
  parameter int NUM_BTN       = 4,
  parameter int NUM_SW        = 4,
  parameter int DCYCLE_WL     = 13,
  parameter int RX_FIFO_DEPTH = 16,
  parameter int ADDR_WL       = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           io_cmd_valid,
  input  logic                           io_cmd_wr,
  input  logic [ADDR_WL-1:0]             io_cmd_addr,
  input  logic [31:0]                    io_cmd_data,
  input  logic [1:0]                     io_cmd_size,
  output logic                           io_rsp_valid,
  output logic                           io_rsp_error,
  output logic [31:0]                    io_rsp_data,
  input  logic [NUM_BTN-1:0]             btn,
  input  logic [NUM_SW-1:0]              sw,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [7:0]                     tx_data,
  output logic [NUM_LEDS-1:0]            leds,
  output logic [3*NUM_RGB-1:0]           rgb_color,
  output logic [DCYCLE_WL*NUM_RGB-1:0]   rgb_dcycle,
  output logic                           irq
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = ADDR_WL - 2;

  logic [31:0]                  debug_q, debug_d;
  logic [NUM_LEDS-1:0]          leds_q, leds_d;
  logic [3*NUM_RGB-1:0]         color_q, color_d;
  logic [DCYCLE_WL*NUM_RGB-1:0] dcycle_q, dcycle_d;
  logic                         tx_valid_q, tx_valid_d;
  logic [7:0]                   tx_data_q, tx_data_d;
  logic                         tx_drop_q, tx_drop_d;
  logic                         rx_ovf_q, rx_ovf_d;
  logic [NUM_BTN-1:0]           btn_q, btn_d;
  logic [NUM_BTN-1:0]           btn_evt_q, btn_evt_d;
  logic [7:0]                   mem_q [RX_FIFO_DEPTH];
  logic [7:0]                   mem_d [RX_FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic                         rsp_error_q, rsp_error_d;
  logic [31:0]                  rsp_data_q, rsp_data_d;
`ifdef IO_IRQ_EN
  logic [3:0]                   irq_mask_q, irq_mask_d;
  logic                         irq_q, irq_d;
`endif

  logic [IW-1:0] idx;
  int            widx;
  logic          wr_en, rd_en, rx_empty, rx_full, pop, push, drop_set, ovf_set, rd_err, rgb_hit;
  logic [3:0]    be;
  logic [31:0]   wmask, rd_data;

  always_comb begin
    idx   = io_cmd_addr[ADDR_WL-1:2];
    widx  = {{(32-IW){1'b0}}, idx};
    wr_en = io_cmd_valid && io_cmd_wr;
    rd_en = io_cmd_valid && !io_cmd_wr;
    case (io_cmd_size)
      2'd0:    be = 4'b0001 << io_cmd_addr[1:0];
      2'd1:    be = io_cmd_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    debug_d    = debug_q;
    leds_d     = leds_q;
    color_d    = color_q;
    dcycle_d   = dcycle_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_drop_d  = tx_drop_q;
    rx_ovf_d   = rx_ovf_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    drop_set   = 1'b0;
    ovf_set    = 1'b0;
`ifdef IO_IRQ_EN
    irq_mask_d = irq_mask_q;
`endif

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    rx_empty = (cnt_q == '0);
    rx_full  = (cnt_q == CW'(RX_FIFO_DEPTH));
    pop      = rd_en && (widx == 2) && !rx_empty;
    push     = rx_valid && (!rx_full || pop);
    ovf_set  = rx_valid && rx_full && !pop;
    if (push) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;

    btn_d     = btn;
    btn_evt_d = btn_evt_q;

    if (wr_en) begin
      case (widx)
        0: debug_d = (debug_q & ~wmask) | (io_cmd_data & wmask);
        1: if (be[0]) begin
             if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
               tx_data_d  = io_cmd_data[7:0];
             end else begin
               drop_set = 1'b1;
             end
           end
        3: if (be[0]) begin
             if (io_cmd_data[2]) rx_ovf_d  = 1'b0;
             if (io_cmd_data[3]) tx_drop_d = 1'b0;
           end
        4: leds_d = (leds_q & ~wmask[NUM_LEDS-1:0]) | (io_cmd_data[NUM_LEDS-1:0] & wmask[NUM_LEDS-1:0]);
        6: btn_evt_d = btn_evt_q & ~(io_cmd_data[NUM_BTN-1:0] & wmask[NUM_BTN-1:0]);
`ifdef IO_IRQ_EN
        8: irq_mask_d = (irq_mask_q & ~wmask[3:0]) | (io_cmd_data[3:0] & wmask[3:0]);
`endif
        default: begin
          for (int k = 0; k < NUM_RGB; k++) begin
            if (widx == 16 + 2*k)
              color_d[3*k +: 3] = (color_q[3*k +: 3] & ~wmask[2:0]) | (io_cmd_data[2:0] & wmask[2:0]);
            if (widx == 17 + 2*k)
              dcycle_d[DCYCLE_WL*k +: DCYCLE_WL] = (dcycle_q[DCYCLE_WL*k +: DCYCLE_WL] & ~wmask[DCYCLE_WL-1:0])
                                                 | (io_cmd_data[DCYCLE_WL-1:0] & wmask[DCYCLE_WL-1:0]);
          end
        end
      endcase
    end

    // Sticky sets are applied after the W1C so a same-cycle event survives the clear.
    if (ovf_set)  rx_ovf_d  = 1'b1;
    if (drop_set) tx_drop_d = 1'b1;
    btn_evt_d = btn_evt_d | (btn & ~btn_q);

    rd_data = '0;
    rd_err  = 1'b0;
    rgb_hit = 1'b0;
    case (widx)
      0: rd_data = debug_q;
      1: rd_data = {31'b0, tx_valid_q};
      2: rd_data = rx_empty ? 32'h0 : {23'b0, 1'b1, mem_q[rd_ptr_q]};
      3: rd_data = {28'b0, tx_drop_q, rx_ovf_q, rx_full, rx_empty};
      4: rd_data = 32'(leds_q);
      5: rd_data = 32'(btn_q);
      6: rd_data = 32'(btn_evt_q);
      7: rd_data = 32'(sw);
`ifdef IO_IRQ_EN
      8: rd_data = {28'b0, irq_mask_q};
`endif
      default: begin
        for (int k = 0; k < NUM_RGB; k++) begin
          if (widx == 16 + 2*k) begin
            rd_data = {29'b0, color_q[3*k +: 3]};
            rgb_hit = 1'b1;
          end
          if (widx == 17 + 2*k) begin
            rd_data = 32'(dcycle_q[DCYCLE_WL*k +: DCYCLE_WL]);
            rgb_hit = 1'b1;
          end
        end
        rd_err = !rgb_hit;
      end
    endcase

    rsp_valid_d = rd_en;
    rsp_error_d = rd_en && rd_err;
    rsp_data_d  = rd_en ? rd_data : '0;
`ifdef IO_IRQ_EN
    irq_d = |(irq_mask_q & {!tx_valid_q, |btn_evt_q, rx_ovf_q, !rx_empty});
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      debug_q     <= '0;
      leds_q      <= '0;
      color_q     <= '0;
      dcycle_q    <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_drop_q   <= 1'b0;
      rx_ovf_q    <= 1'b0;
      btn_q       <= '0;
      btn_evt_q   <= '0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef IO_IRQ_EN
      irq_mask_q  <= '0;
      irq_q       <= 1'b0;
`endif
    end else begin
      debug_q     <= debug_d;
      leds_q      <= leds_d;
      color_q     <= color_d;
      dcycle_q    <= dcycle_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      tx_drop_q   <= tx_drop_d;
      rx_ovf_q    <= rx_ovf_d;
      btn_q       <= btn_d;
      btn_evt_q   <= btn_evt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
`ifdef IO_IRQ_EN
      irq_mask_q  <= irq_mask_d;
      irq_q       <= irq_d;
`endif
    end
  end

  assign io_rsp_valid = rsp_valid_q;
  assign io_rsp_error = rsp_error_q;
  assign io_rsp_data  = rsp_data_q;
  assign tx_valid     = tx_valid_q;
  assign tx_data      = tx_data_q;
  assign leds         = leds_q;
  assign rgb_color    = color_q;
  assign rgb_dcycle   = dcycle_q;
`ifdef IO_IRQ_EN
  assign irq          = irq_q;
`else
  assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_io_periph_regs.sv
// Randomised bench for io_periph_regs against a queue-based register model, plus directed boundary cases.
module tb_io_periph_regs;

  localparam int RXD = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_cmd_valid, io_cmd_wr;
  logic [7:0]  io_cmd_addr;
  logic [31:0] io_cmd_data;
  logic [1:0]  io_cmd_size;
  logic        io_rsp_valid, io_rsp_error;
  logic [31:0] io_rsp_data;
  logic [3:0]  btn, sw;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic [15:0] leds;
  logic [5:0]  rgb_color;
  logic [25:0] rgb_dcycle;
  logic        irq;

  io_periph_regs #(
    .NUM_LEDS(16), .NUM_RGB(2), .NUM_BTN(4), .NUM_SW(4),
    .DCYCLE_WL(13), .RX_FIFO_DEPTH(RXD), .ADDR_WL(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .io_cmd_valid(io_cmd_valid), .io_cmd_wr(io_cmd_wr), .io_cmd_addr(io_cmd_addr),
    .io_cmd_data(io_cmd_data), .io_cmd_size(io_cmd_size),
    .io_rsp_valid(io_rsp_valid), .io_rsp_error(io_rsp_error), .io_rsp_data(io_rsp_data),
    .btn(btn), .sw(sw), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .leds(leds), .rgb_color(rgb_color), .rgb_dcycle(rgb_dcycle), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_debug;
  logic [15:0] m_leds;
  logic [2:0]  m_color [2];
  logic [12:0] m_dc [2];
  logic        m_txv, m_drop, m_ovf, m_irq;
  logic [7:0]  m_txd;
  logic [7:0]  m_fifo [$];
  logic [3:0]  m_btnq, m_evt, m_mask;
  logic        exp_v, exp_e;
  logic [31:0] exp_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_debug = '0; m_leds = '0; m_txv = 1'b0; m_drop = 1'b0; m_ovf = 1'b0; m_irq = 1'b0;
    m_txd = '0; m_btnq = '0; m_evt = '0; m_mask = '0;
    for (int k = 0; k < 2; k++) begin m_color[k] = '0; m_dc[k] = '0; end
    m_fifo.delete();
  endtask

  function automatic logic [31:0] lane_mask(input logic [7:0] a, input logic [1:0] s);
    logic [31:0] m;
    logic        on;
    int          ai;
    m  = '0;
    ai = int'(a);
    for (int b = 0; b < 4; b++) begin
      if (s == 2'd0)      on = (b == ai % 4);
      else if (s == 2'd1) on = (b / 2 == (ai / 2) % 2);
      else                on = 1'b1;
      if (on) m[b*8 +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // One bus cycle of the register map, evaluated on the state before the clock edge.
  task automatic model_step(input logic v, input logic w, input logic [7:0] a,
                            input logic [31:0] d, input logic [1:0] s);
    int          idx, nb;
    logic [31:0] m, rd;
    logic        err, pop, drop_set, ovf_set, was_txv, irq_nx;
    idx = int'(a) / 4;
    nb  = m_fifo.size();
    m   = lane_mask(a, s);
    was_txv = m_txv;
    rd = '0; err = 1'b0; drop_set = 1'b0; ovf_set = 1'b0;
    exp_v = v && !w;
    case (idx)
      0: rd = m_debug;
      1: rd = {31'b0, m_txv};
      2: rd = (nb > 0) ? {23'b0, 1'b1, m_fifo[0]} : 32'h0;
      3: rd = {28'b0, m_drop, m_ovf, nb == RXD, nb == 0};
      4: rd = {16'b0, m_leds};
      5: rd = {28'b0, m_btnq};
      6: rd = {28'b0, m_evt};
      7: rd = {28'b0, sw};
`ifdef IO_IRQ_EN
      8: rd = {28'b0, m_mask};
`endif
      16, 18: rd = {29'b0, m_color[(idx-16)/2]};
      17, 19: rd = {19'b0, m_dc[(idx-17)/2]};
      default: err = 1'b1;
    endcase
    exp_d = rd;
    exp_e = exp_v && err;
`ifdef IO_IRQ_EN
    irq_nx = |(m_mask & {!m_txv, |m_evt, m_ovf, nb != 0});
`else
    irq_nx = 1'b0;
`endif
    pop = exp_v && idx == 2 && nb > 0;
    if (was_txv && tx_ready) m_txv = 1'b0;
    if (v && w) begin
      case (idx)
        0: m_debug = (m_debug & ~m) | (d & m);
        1: if (m[0]) begin
             if (!was_txv) begin m_txv = 1'b1; m_txd = d[7:0]; end
             else drop_set = 1'b1;
           end
        3: if (m[0]) begin
             if (d[2]) m_ovf = 1'b0;
             if (d[3]) m_drop = 1'b0;
           end
        4: m_leds = (m_leds & ~m[15:0]) | (d[15:0] & m[15:0]);
        6: m_evt = m_evt & ~(d[3:0] & m[3:0]);
`ifdef IO_IRQ_EN
        8: m_mask = (m_mask & ~m[3:0]) | (d[3:0] & m[3:0]);
`endif
        16, 18: m_color[(idx-16)/2] = (m_color[(idx-16)/2] & ~m[2:0]) | (d[2:0] & m[2:0]);
        17, 19: m_dc[(idx-17)/2] = (m_dc[(idx-17)/2] & ~m[12:0]) | (d[12:0] & m[12:0]);
        default: ;
      endcase
    end
    if (pop) void'(m_fifo.pop_front());
    if (rx_valid) begin
      if (nb < RXD || pop) m_fifo.push_back(rx_data);
      else ovf_set = 1'b1;
    end
    if (ovf_set)  m_ovf  = 1'b1;
    if (drop_set) m_drop = 1'b1;
    m_evt  = m_evt | (btn & ~m_btnq);
    m_btnq = btn;
    m_irq  = irq_nx;
  endtask

  task automatic cyc(input logic v, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic [1:0] s);
    logic [5:0]  ec;
    logic [25:0] ed;
    io_cmd_valid = v; io_cmd_wr = w; io_cmd_addr = a; io_cmd_data = d; io_cmd_size = s;
    model_step(v, w, a, d, s);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      ec[3*k +: 3]   = m_color[k];
      ed[13*k +: 13] = m_dc[k];
    end
    chk("rsp_vld", 32'(io_rsp_valid), 32'(exp_v));
    if (exp_v) begin
      chk("rsp_dat", io_rsp_data, exp_d);
      chk("rsp_err", 32'(io_rsp_error), 32'(exp_e));
    end
    chk("leds", 32'(leds), 32'(m_leds));
    chk("tx_vld", 32'(tx_valid), 32'(m_txv));
    if (m_txv) chk("tx_dat", 32'(tx_data), 32'(m_txd));
    chk("rgb_col", 32'(rgb_color), 32'(ec));
    chk("rgb_dc", 32'(rgb_dcycle), 32'(ed));
    chk("irq", 32'(irq), 32'(m_irq));
    io_cmd_valid = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 32'h0, 2'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    io_cmd_valid = 1'b0; io_cmd_wr = 1'b0; io_cmd_addr = '0; io_cmd_data = '0; io_cmd_size = '0;
    btn = '0; sw = '0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_vld", 32'(tx_valid), 32'h0);
    chk("rst_tx_dat", 32'(tx_data), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_rsp_vld", 32'(io_rsp_valid), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    idle();

    // Byte-lane write into LEDS
    cyc(1, 1, 8'h10, 32'h0000_00FF, 2'd2);
    cyc(1, 1, 8'h11, 32'h0000_AB00, 2'd0);
    chk("led_byte", 32'(leds), 32'h0000_ABFF);
    cyc(1, 0, 8'h10, 32'h0, 2'd2);
    chk("led_rd", io_rsp_data, 32'h0000_ABFF);

    // RX FIFO fill past full, then drain past empty
    for (int i = 1; i <= 17; i++) begin
      rx_valid = 1'b1; rx_data = 8'(i);
      idle();
    end
    cyc(1, 0, 8'h0C, 32'h0, 2'd2);
    chk("stat_full_ovf", io_rsp_data, 32'h6);
    for (int i = 0; i < 17; i++) begin
      cyc(1, 0, 8'h08, 32'h0, 2'd2);
      chk("rx_pop", io_rsp_data, (i < 16) ? 32'h101 + 32'(i) : 32'h0);
    end
    cyc(1, 0, 8'h0C, 32'h0, 2'd2);
    chk("stat_empty", 32'(io_rsp_data[0]), 32'h1);
    cyc(1, 1, 8'h0C, 32'h4, 2'd2);
    cyc(1, 0, 8'h0C, 32'h0, 2'd2);
    chk("stat_ovf_clr", io_rsp_data, 32'h1);

    // Push and pop on the same cycle while full: no overflow, stays full
    for (int i = 0; i < RXD; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'h20 + i);
      idle();
    end
    rx_valid = 1'b1; rx_data = 8'hAA;
    cyc(1, 0, 8'h08, 32'h0, 2'd2);
    chk("full_pushpop", io_rsp_data, 32'h120);
    cyc(1, 0, 8'h0C, 32'h0, 2'd2);
    chk("full_no_ovf", io_rsp_data, 32'h2);
    for (int i = 0; i < RXD; i++) cyc(1, 0, 8'h08, 32'h0, 2'd2);
    // Push and pop on the same cycle while empty: read returns 0, byte stays
    rx_valid = 1'b1; rx_data = 8'h5A;
    cyc(1, 0, 8'h08, 32'h0, 2'd2);
    chk("empty_pushpop", io_rsp_data, 32'h0);
    cyc(1, 0, 8'h08, 32'h0, 2'd2);
    chk("empty_kept", io_rsp_data, 32'h15A);

    // TX hold, drop and handshake
    tx_ready = 1'b0;
    cyc(1, 1, 8'h04, 32'h41, 2'd0);
    cyc(1, 1, 8'h04, 32'h42, 2'd0);
    chk("tx_hold", 32'(tx_data), 32'h41);
    cyc(1, 0, 8'h0C, 32'h0, 2'd2);
    chk("tx_drop", 32'(io_rsp_data[3]), 32'h1);
    tx_ready = 1'b1;
    idle();
    chk("tx_done", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    cyc(1, 1, 8'h0C, 32'h8, 2'd2);

    // Button edge on the same cycle as its W1C
    btn = 4'b0100;
    cyc(1, 1, 8'h18, 32'h4, 2'd2);
    cyc(1, 0, 8'h18, 32'h0, 2'd2);
    chk("btn_set_wins", io_rsp_data, 32'h4);
    cyc(1, 1, 8'h18, 32'h4, 2'd2);
    cyc(1, 0, 8'h18, 32'h0, 2'd2);
    chk("btn_cleared", io_rsp_data, 32'h0);
    btn = 4'b0000;

    // Unmapped read
    cyc(1, 0, 8'h30, 32'h0, 2'd2);
    chk("unmap_err", 32'(io_rsp_error), 32'h1);
    chk("unmap_dat", io_rsp_data, 32'h0);

`ifdef IO_IRQ_EN
    cyc(1, 1, 8'h20, 32'h1, 2'd2);
    rx_valid = 1'b1; rx_data = 8'h33;
    idle();
    idle();
    chk("irq_rise", 32'(irq), 32'h1);
    cyc(1, 0, 8'h08, 32'h0, 2'd2);
    idle();
    chk("irq_fall", 32'(irq), 32'h0);
`else
    cyc(1, 0, 8'h20, 32'h0, 2'd2);
    chk("mask_unmapped", 32'(io_rsp_error), 32'h1);
`endif

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      int          ix;
      logic        v, w;
      logic [31:0] d;
      if ($urandom_range(0, 7) == 0) btn = 4'($urandom);
      if ($urandom_range(0, 15) == 0) sw = 4'($urandom);
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      ix = ($urandom_range(0, 3) == 0) ? 2 : int'($urandom_range(0, 23));
      v  = ($urandom_range(0, 4) != 0);
      w  = $urandom_range(0, 1) == 1;
      d  = $urandom;
      cyc(v, w, 8'(ix * 4 + int'($urandom_range(0, 3))), d, 2'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a pending TX and an in-flight read
    tx_ready = 1'b0;
    cyc(1, 1, 8'h04, 32'h77, 2'd2);
    cyc(1, 1, 8'h10, 32'hFFFF, 2'd2);
    io_cmd_valid = 1'b1; io_cmd_wr = 1'b0; io_cmd_addr = 8'h00; io_cmd_size = 2'd2;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_tx_vld", 32'(tx_valid), 32'h0);
    chk("arst_leds", 32'(leds), 32'h0);
    chk("arst_rsp_vld", 32'(io_rsp_valid), 32'h0);
    io_cmd_valid = 1'b0;
    btn = '0; sw = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1, 0, 8'h00, 32'h0, 2'd2);
    chk("post_rst_debug", io_rsp_data, 32'h0);
    for (int ix = 0; ix < 20; ix++) cyc(1, 0, 8'(ix * 4), 32'h0, 2'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_periph_regs.md
Name: io_periph_regs

Overview:
- Parametrised memory-mapped IO register block for the VexRiscv data bus. It replaces the fixed 16-entry IO register array in the top level.
- Channel counts are generalised: LEDs, RGB channels, buttons and switches.
- Adds a UART RX FIFO with pop-on-read, a handshaked UART TX byte port, sticky write-1-to-clear button events, per-address error response, and a registered 1-cycle read response.
- Sits between the dBus decode (io_slct asserted) and the board IO, debouncers and PWMs.

Parameters:
- NUM_LEDS, 4, LED output count (1..32)
- NUM_RGB, 2, RGB channel count (1..8)
- NUM_BTN, 4, debounced button inputs (1..32)
- NUM_SW, 4, switch inputs (1..32)
- DCYCLE_WL, 13, PWM duty-cycle width per RGB channel (1..32)
- RX_FIFO_DEPTH, 16, UART RX FIFO entries, power of 2, >=2
- ADDR_WL, 8, byte-address width of IO space (word index = addr[ADDR_WL-1:2])

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- io_cmd_valid  in  1  bus command valid (already IO-selected)
- io_cmd_wr  in  1  1=write, 0=read
- io_cmd_addr  in  ADDR_WL  byte address
- io_cmd_data  in  32  write data
- io_cmd_size  in  2  0=byte, 1=half, 2/3=word
- io_rsp_valid  out  1  read data valid
- io_rsp_error  out  1  read of unmapped address
- io_rsp_data  out  32  read data
- btn  in  NUM_BTN  debounced buttons
- sw  in  NUM_SW  switches
- rx_valid  in  1  UART RX byte strobe (1 cycle)
- rx_data  in  8  UART RX byte
- tx_valid  out  1  TX byte pending
- tx_ready  in  1  UART TX accepts byte
- tx_data  out  8  TX byte
- leds  out  NUM_LEDS  LED drive
- rgb_color  out  3*NUM_RGB  per-channel {b,g,r} enables
- rgb_dcycle  out  DCYCLE_WL*NUM_RGB  per-channel duty cycle
- irq  out  1  interrupt (0 unless IO_IRQ_EN)

Behaviour:
- Reset (reset_n=0, async): all registers, FIFO pointers, sticky bits and outputs are 0; io_rsp_valid=0, tx_valid=0.
- Word map (index):
  - 0 DEBUG rw
  - 1 UART_TX: write pushes byte; read = {31'b0, tx_valid}
  - 2 UART_RX: read pops, returns {23'b0, valid, data}; empty returns 0 and does not pop
  - 3 UART_STAT ro/W1C: bit0 empty, bit1 full, bit2 rx_ovf (sticky, W1C), bit3 tx_drop (sticky, W1C)
  - 4 LEDS rw
  - 5 BTN_STATE ro
  - 6 BTN_EVENT W1C
  - 7 SW ro
  - 8 IRQ_MASK
  - 16+2k RGBk_COLOR rw [2:0]
  - 17+2k RGBk_DCYCLE rw
  - All other indices unmapped.
- Read timing: cmd accepted every cycle. Read at cycle N produces io_rsp_valid=1 at N+1 with registered data. Writes never raise io_rsp_valid.
- Unmapped read: data 0, io_rsp_error=1. Unmapped write is ignored.
- Write byte lanes: size 0 -> lane addr[1:0]; size 1 -> lanes addr[1:0]&2 (pair); size >=2 -> all four. Applied to rw registers. Unimplemented upper bits read 0.
- TX: a write with lane0 enabled while tx_valid=0 loads tx_data and sets tx_valid. tx_valid clears the cycle after tx_valid&&tx_ready. A write while tx_valid=1 is dropped and sets tx_drop.
- RX FIFO: rx_valid pushes.
  - Push when full: data discarded, rx_ovf set.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Pop and push in the same cycle when empty: read returns 0, pushed byte stays.
  - Pointers wrap modulo RX_FIFO_DEPTH; count width is log2(depth)+1.
- BTN_EVENT[i] sets on a rising edge of btn[i] (btn registered once internally). W1C clears. A set and a clear on the same cycle: set wins.
- W1C on UART_STAT follows the same rule: a sticky event on the same cycle wins over the clear.

Optional Feature:
- Macro: IO_IRQ_EN.
- Defined: IRQ_MASK bits are rw. Bit0 = RX not empty, bit1 = rx_ovf, bit2 = any BTN_EVENT, bit3 = TX idle. irq = |(mask & sources), registered (one-cycle delay).
- Undefined: IRQ_MASK is unmapped (read error), irq tied 0.

Test Plan:
- Reset: pulse reset_n low mid-TX (tx_valid=1) -> tx_valid, leds, io_rsp_valid=0 immediately; all reads return 0.
- Byte write: write size=0 addr 0x11 data 0x0000AB00 to LEDS (NUM_LEDS=16), prior value 0x00FF -> leds=0xABFF; read returns 0x0000ABFF one cycle after cmd.
- RX FIFO: push 17 bytes 0x01..0x11 (depth 16) -> STAT=0x6 (full, ovf). 16 pops return 0x101..0x110; 17th pop returns 0; STAT bit0=1. Write STAT 0x4 -> ovf clears.
- TX: write 0x41 with tx_ready=0, then write 0x42 -> tx_data=0x41, tx_drop=1. Assert tx_ready -> tx_valid falls the next cycle.
- Button: btn[2] rises on the same cycle as a W1C of 0x4 to BTN_EVENT -> BTN_EVENT=0x4 retained. A second W1C clears it to 0.
- Unmapped read at index 12 -> io_rsp_error=1, data 0. With IO_IRQ_EN: mask=0x1, push one byte -> irq=1 two cycles after rx_valid; pop -> irq=0.
